// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU control codes, MIPS opcode/funct values and the decoded-op record
// used by the ALU issue stage and its decoder.
package alu_issue_stage_pkg;

    typedef enum logic [3:0] {
        ALU_DISABLED   = 4'd0,
        ALU_ADD        = 4'd1,
        ALU_SUB        = 4'd2,
        ALU_OR         = 4'd3,
        ALU_AND        = 4'd4,
        ALU_SHIFT_LEFT = 4'd5,
        ALU_XOR        = 4'd6,
        ALU_NOR        = 4'd7
    } alu_ctrl_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    typedef struct packed {
        alu_ctrl_e   ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        illegal;
    } issue_op_t;

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Pure combinational MIPS-subset decoder: instruction word plus register
// operands into ALU control, operands, destination and an illegal flag.
module alu_op_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output issue_op_t   op
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        unused_rs_field;

    assign opcode   = instr[31:26];
    assign rt_field = instr[20:16];
    assign rd_field = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    // The rs register number is already resolved into rs_value upstream.
    assign unused_rs_field = ^instr[25:21];

    // Illegal encodings fall through with all fields left at zero.
    always_comb begin
        op = '0;
        case (opcode)
            OP_RTYPE: begin
                op.dest = rd_field;
                op.a    = rs_value;
                op.b    = rt_value;
                case (funct)
                    FN_ADDU: op.ctrl = ALU_ADD;
                    FN_SUBU: op.ctrl = ALU_SUB;
                    FN_AND:  op.ctrl = ALU_AND;
                    FN_OR:   op.ctrl = ALU_OR;
                    FN_XOR:  op.ctrl = ALU_XOR;
                    FN_NOR:  op.ctrl = ALU_NOR;
                    FN_SLL: begin
                        op.ctrl = ALU_SHIFT_LEFT;
                        op.a    = rt_value;
                        op.b    = {27'b0, shamt};
                    end
                    FN_SLLV: begin
                        op.ctrl = ALU_SHIFT_LEFT;
                        op.a    = rt_value;
                        op.b    = {27'b0, rs_value[4:0]};
                    end
                    default: begin
                        op         = '0;
                        op.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDIU: begin
                op.ctrl = ALU_ADD;
                op.a    = rs_value;
                op.b    = {{16{imm[15]}}, imm};
                op.dest = rt_field;
            end
            OP_ANDI: begin
                op.ctrl = ALU_AND;
                op.a    = rs_value;
                op.b    = {16'b0, imm};
                op.dest = rt_field;
            end
            OP_ORI: begin
                op.ctrl = ALU_OR;
                op.a    = rs_value;
                op.b    = {16'b0, imm};
                op.dest = rt_field;
            end
            OP_XORI: begin
                op.ctrl = ALU_XOR;
                op.a    = rs_value;
                op.b    = {16'b0, imm};
                op.dest = rt_field;
            end
            OP_LUI: begin
                op.ctrl = ALU_SHIFT_LEFT;
                op.a    = {16'b0, imm};
                op.b    = 32'd16;
                op.dest = rt_field;
            end
            default: op.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage feeding the ALU: one-entry output register with
// valid/ready handshake, flush and a saturating illegal-op counter.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs_value,
    input  logic [31:0]      rt_value,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_ctrl,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [4:0]       dest_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    issue_op_t        op_p0;
    issue_op_t        op_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             accept;

    // Stage p0: combinational decode of the incoming instruction
    alu_op_decode u_decode (
        .instr    (instr),
        .rs_value (rs_value),
        .rt_value (rt_value),
        .op       (op_p0)
    );

    assign in_ready = !flush && (!vld_p1 || out_ready);
    assign accept   = in_valid && in_ready;

    // Stage p1: output register toward execute
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            if (op_p0.illegal)
                cnt_p1 <= sat_inc(cnt_p1);
        end else if (flush || out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Payload only moves on accept; a flush leaves the stale op in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            op_p1 <= '0;
        else if (accept)
            op_p1 <= op_p0;
    end

    assign out_valid     = vld_p1;
    assign alu_ctrl      = op_p1.ctrl;
    assign alu_a         = op_p1.a;
    assign alu_b         = op_p1.b;
    assign dest_reg      = op_p1.dest;
    assign illegal       = op_p1.illegal;
    assign illegal_count = cnt_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Table-driven, scoreboarded bench for alu_issue_stage.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  dest_reg;
    logic        illegal;
    logic [7:0]  illegal_count;

    always #5 clk = ~clk;

    alu_issue_stage #(.CNT_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .rs_value      (rs_value),
        .rt_value      (rt_value),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_ctrl      (alu_ctrl),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .dest_reg      (dest_reg),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        ill;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        exp_t        e;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   model_cnt = 0;
    exp_t sb[$];
    exp_t cur_exp;
    vec_t tbl[15];

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {opc, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic exp_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] d, input logic ill);
        exp_t e;
        e.ctrl = c; e.a = a; e.b = b; e.dest = d; e.ill = ill; e.cnt = 8'd0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: pop on output transfer (or discard on flush), push on accept.
    always @(negedge clk) begin
        if (reset_n) begin
            if (flush) begin
                if (out_valid && sb.size() > 0) void'(sb.pop_front());
            end else if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: output ctrl=%0h with no expected op", alu_ctrl);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (alu_ctrl !== e.ctrl || alu_a !== e.a || alu_b !== e.b ||
                        dest_reg !== e.dest || illegal !== e.ill || illegal_count !== e.cnt) begin
                        errors++;
                        $display("FAIL issue_op: got ctrl=%0h a=%0h b=%0h dest=%0d ill=%0b cnt=%0d, expected ctrl=%0h a=%0h b=%0h dest=%0d ill=%0b cnt=%0d",
                                 alu_ctrl, alu_a, alu_b, dest_reg, illegal, illegal_count,
                                 e.ctrl, e.a, e.b, e.dest, e.ill, e.cnt);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = cur_exp;
                if (e.ill) model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;
                e.cnt = 8'(model_cnt);
                sb.push_back(e);
            end
        end
    end

    task automatic wait_accept();
        bit done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input vec_t v);
        in_valid = 1'b1;
        instr    = v.instr;
        rs_value = v.rs;
        rt_value = v.rt;
        cur_exp  = v.e;
    endtask

    task automatic drive(input vec_t v);
        set_in(v);
        wait_accept();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        vec_t ill_v;
        tbl[0]  = '{rtype(1, 2, 3, 0, 6'h21), 32'd5, 32'd7, mk(4'd1, 32'd5, 32'd7, 5'd3, 1'b0)};
        tbl[1]  = '{itype(6'h09, 1, 4, 16'hFFFF), 32'd10, 32'd0, mk(4'd1, 32'd10, 32'hFFFF_FFFF, 5'd4, 1'b0)};
        tbl[2]  = '{itype(6'h0D, 1, 6, 16'hFFFF), 32'h1234_0000, 32'd0, mk(4'd3, 32'h1234_0000, 32'h0000_FFFF, 5'd6, 1'b0)};
        tbl[3]  = '{itype(6'h0F, 0, 5, 16'h1234), 32'hDEAD, 32'd0, mk(4'd5, 32'h1234, 32'd16, 5'd5, 1'b0)};
        tbl[4]  = '{rtype(8, 9, 7, 0, 6'h23), 32'd100, 32'd30, mk(4'd2, 32'd100, 32'd30, 5'd7, 1'b0)};
        tbl[5]  = '{rtype(1, 2, 10, 0, 6'h24), 32'hF0F0, 32'hFF00, mk(4'd4, 32'hF0F0, 32'hFF00, 5'd10, 1'b0)};
        tbl[6]  = '{rtype(1, 2, 11, 0, 6'h25), 32'h1, 32'h2, mk(4'd3, 32'h1, 32'h2, 5'd11, 1'b0)};
        tbl[7]  = '{rtype(1, 2, 12, 0, 6'h26), 32'hAAAA, 32'h5555, mk(4'd6, 32'hAAAA, 32'h5555, 5'd12, 1'b0)};
        tbl[8]  = '{rtype(1, 2, 13, 0, 6'h27), 32'h3, 32'h4, mk(4'd7, 32'h3, 32'h4, 5'd13, 1'b0)};
        tbl[9]  = '{rtype(3, 9, 14, 4, 6'h00), 32'hABCD, 32'h11, mk(4'd5, 32'h11, 32'd4, 5'd14, 1'b0)};
        tbl[10] = '{rtype(3, 9, 15, 0, 6'h04), 32'h25, 32'h3, mk(4'd5, 32'h3, 32'd5, 5'd15, 1'b0)};
        tbl[11] = '{itype(6'h0C, 1, 16, 16'h8001), 32'hFFFF_FFFF, 32'd0, mk(4'd4, 32'hFFFF_FFFF, 32'h0000_8001, 5'd16, 1'b0)};
        tbl[12] = '{itype(6'h0E, 1, 17, 16'hFFFF), 32'h0F0F_0F0F, 32'd0, mk(4'd6, 32'h0F0F_0F0F, 32'h0000_FFFF, 5'd17, 1'b0)};
        tbl[13] = '{itype(6'h3F, 1, 18, 16'h1234), 32'h55, 32'h66, mk(4'd0, 32'd0, 32'd0, 5'd0, 1'b1)};
        tbl[14] = '{rtype(1, 2, 19, 0, 6'h20), 32'h77, 32'h88, mk(4'd0, 32'd0, 32'd0, 5'd0, 1'b1)};

        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = '0; rs_value = '0; rt_value = '0; cur_exp = tbl[0].e;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, alu_ctrl, alu_a, alu_b, dest_reg, illegal, illegal_count},
              64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back table traffic with the consumer always ready
        drive(tbl[0]);
        check("latency_valid", 64'(out_valid), 64'd1);
        for (int i = 1; i < 15; i++) drive(tbl[i]);
        idle();
        drain();

        // Stall: op held while next op waits, then simultaneous drain+accept
        out_ready = 1'b0;
        drive(tbl[0]);
        set_in(tbl[4]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_hold", {out_valid, alu_ctrl, alu_a[15:0], alu_b[15:0], dest_reg},
                  {1'b1, 4'd1, 16'd5, 16'd7, 5'd3});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        check("no_gap_valid", 64'(out_valid), 64'd1);
        drive(tbl[5]);
        idle();
        drain();

        // Flush a held op while a new one is offered
        out_ready = 1'b0;
        drive(tbl[1]);
        set_in(tbl[2]);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_stale_b", 64'(alu_b), 64'hFFFF_FFFF);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("flush_no_issue", 64'(sb.size()), 64'd0);

        // Illegal flood: counter saturates
        ill_v = tbl[13];
        for (int i = 0; i < 300; i++) begin
            ill_v.instr = itype(6'h3F, i % 32, (i * 7) % 32, 16'(i));
            drive(ill_v);
        end
        idle();
        drain();
        check("count_saturated", 64'(illegal_count), 64'd255);

        // Asynchronous reset mid-transfer
        out_ready = 1'b0;
        drive(tbl[3]);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset", {out_valid, alu_ctrl, alu_a, alu_b, dest_reg, illegal, illegal_count},
              64'd0);
        sb.delete();
        model_cnt = 0;
        idle();
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        drive(tbl[4]);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
